// File: rtl/anita3_evt_pkg.sv
// Shared constants for the ANITA-3 event builder: record word layout,
// buffer count and FSM state encoding.
package anita3_evt_pkg;

  localparam logic [7:0] MAGIC = 8'hA3;

  localparam int REC_LEN     = 9;
  localparam int NUM_BUFFERS = 2;

  localparam logic [5:0] W_TYPE   = 6'd0;
  localparam logic [5:0] W_NUM_LO = 6'd1;
  localparam logic [5:0] W_NUM_HI = 6'd2;
  localparam logic [5:0] W_PPS    = 6'd3;
  localparam logic [5:0] W_CLK_LO = 6'd4;
  localparam logic [5:0] W_CLK_HI = 6'd5;
  localparam logic [5:0] W_L3_LO  = 6'd6;
  localparam logic [5:0] W_L3_HI  = 6'd7;
  localparam logic [5:0] W_CKSUM  = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/anita3_event_builder.sv
// Packs an accepted trigger header into a 9-word record with checksum and
// writes it into one half of the double-buffered event RAM.
module anita3_event_builder
  import anita3_evt_pkg::*;
(
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic        evt_valid_i,
  output logic        evt_ready_o,
  input  logic [7:0]  evt_type_i,
  input  logic [31:0] evt_number_i,
  input  logic [15:0] evt_pps_i,
  input  logic [31:0] evt_clock_i,
  input  logic [31:0] evt_l3_i,
  input  logic        clear_evt_i,
  output logic [7:0]  event_wr_addr_o,
  output logic [15:0] event_wr_dat_o,
  output logic        event_wr_o,
  output logic        event_done_o,
  output logic        busy_o,
  output logic [1:0]  occupancy_o,
  output logic        err_underflow_o
);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        wbuf_q, wbuf_d;
  logic [1:0]  occ_q, occ_d;
  logic        err_q, err_d;
  logic [7:0]  type_q, type_d;
  logic [31:0] number_q, number_d;
  logic [15:0] pps_q, pps_d;
  logic [31:0] clock_q, clock_d;
  logic [31:0] l3_q, l3_d;
  logic [15:0] cksum_q, cksum_d;

  logic [15:0] word;
  logic        accept;
  logic        occ_inc;
  logic        occ_dec;

  always_comb begin
    word = cksum_q;
    case (idx_q)
      W_TYPE:   word = {MAGIC, type_q};
      W_NUM_LO: word = number_q[15:0];
      W_NUM_HI: word = number_q[31:16];
      W_PPS:    word = pps_q;
      W_CLK_LO: word = clock_q[15:0];
      W_CLK_HI: word = clock_q[31:16];
      W_L3_LO:  word = l3_q[15:0];
      W_L3_HI:  word = l3_q[31:16];
      default:  word = cksum_q;
    endcase
  end

  assign evt_ready_o = (state_q == ST_IDLE) && (occ_q < 2'(NUM_BUFFERS));
  assign accept      = evt_valid_i & evt_ready_o;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wbuf_d   = wbuf_q;
    cksum_d  = cksum_q;
    type_d   = type_q;
    number_d = number_q;
    pps_d    = pps_q;
    clock_d  = clock_q;
    l3_d     = l3_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          type_d   = evt_type_i;
          number_d = evt_number_i;
          pps_d    = evt_pps_i;
          clock_d  = evt_clock_i;
          l3_d     = evt_l3_i;
          idx_d    = W_TYPE;
          cksum_d  = 16'h0000;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The checksum word itself is never folded back into the sum.
        if (idx_q == 6'(REC_LEN - 1)) begin
          state_d = ST_DONE;
        end else begin
          cksum_d = cksum_q + word;
          idx_d   = idx_q + 6'd1;
        end
      end
      ST_DONE: begin
        wbuf_d  = ~wbuf_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fill and a release in the same cycle cancel; a release with nothing
  // held is dropped and flagged.
  always_comb begin
    occ_inc = (state_q == ST_DONE);
    occ_dec = clear_evt_i && (occ_q != 2'd0);
    occ_d   = occ_q + {1'b0, occ_inc} - {1'b0, occ_dec};
    err_d   = err_q | (clear_evt_i && (occ_q == 2'd0));
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= 6'd0;
      wbuf_q   <= 1'b0;
      occ_q    <= 2'd0;
      err_q    <= 1'b0;
      cksum_q  <= 16'h0000;
      type_q   <= 8'h00;
      number_q <= 32'h0;
      pps_q    <= 16'h0;
      clock_q  <= 32'h0;
      l3_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wbuf_q   <= wbuf_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
      cksum_q  <= cksum_d;
      type_q   <= type_d;
      number_q <= number_d;
      pps_q    <= pps_d;
      clock_q  <= clock_d;
      l3_q     <= l3_d;
    end
  end

  assign event_wr_o      = (state_q == ST_WRITE);
  assign event_done_o    = (state_q == ST_DONE);
  assign event_wr_addr_o = (state_q == ST_IDLE) ? {1'b0, wbuf_q, 6'd0} : {1'b0, wbuf_q, idx_q};
  assign event_wr_dat_o  = (state_q == ST_WRITE) ? word : 16'h0000;
  assign busy_o          = ~evt_ready_o;
  assign occupancy_o     = occ_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_anita3_event_builder.sv
// Scoreboard bench for anita3_event_builder: stimulus pushes the expected
// RAM writes and done pulses, a monitor pops and compares them.
module tb_anita3_event_builder;

  typedef struct {
    logic [7:0]  typ;
    logic [31:0] num;
    logic [15:0] pps;
    logic [31:0] clk;
    logic [31:0] l3;
    logic [15:0] cks;
  } evt_t;

  typedef struct {
    logic        isDone;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk33 = 1'b0;
  logic        rst = 1'b1;
  logic        evtValid = 1'b0;
  logic        evtReady;
  logic [7:0]  evtType = 8'h00;
  logic [31:0] evtNumber = 32'h0;
  logic [15:0] evtPps = 16'h0;
  logic [31:0] evtClock = 32'h0;
  logic [31:0] evtL3 = 32'h0;
  logic        clearEvt = 1'b0;
  logic [7:0]  wrAddr;
  logic [15:0] wrDat;
  logic        wrStrobe;
  logic        doneStrobe;
  logic        busy;
  logic [1:0]  occupancy;
  logic        errUnderflow;

  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];
  logic modelBuf = 1'b0;
  int   modelOcc = 0;

  // Hand-computed checksums of words 0..7 (mod 2^16).
  evt_t evA = '{8'h05, 32'h0001_0002, 16'h0003, 32'h0004_0005, 32'h0006_0007, 16'hA321};
  evt_t evB = '{8'h01, 32'h0000_0010, 16'h0020, 32'h0000_0030, 32'h0000_0040, 16'hA3A1};
  evt_t evC = '{8'h02, 32'h0000_0000, 16'h0000, 32'h0000_0000, 32'h0000_0000, 16'hA302};
  evt_t evF = '{8'hFF, 32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hA3F8};

  anita3_event_builder dut (
    .clk33_i        (clk33),
    .rst_i          (rst),
    .evt_valid_i    (evtValid),
    .evt_ready_o    (evtReady),
    .evt_type_i     (evtType),
    .evt_number_i   (evtNumber),
    .evt_pps_i      (evtPps),
    .evt_clock_i    (evtClock),
    .evt_l3_i       (evtL3),
    .clear_evt_i    (clearEvt),
    .event_wr_addr_o(wrAddr),
    .event_wr_dat_o (wrDat),
    .event_wr_o     (wrStrobe),
    .event_done_o   (doneStrobe),
    .busy_o         (busy),
    .occupancy_o    (occupancy),
    .err_underflow_o(errUnderflow)
  );

  always #15 clk33 = ~clk33;

  function automatic logic [15:0] wordOf(input evt_t e, input int k);
    case (k)
      0: return {8'hA3, e.typ};
      1: return e.num[15:0];
      2: return e.num[31:16];
      3: return e.pps;
      4: return e.clk[15:0];
      5: return e.clk[31:16];
      6: return e.l3[15:0];
      7: return e.l3[31:16];
      default: return e.cks;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pushRecord(input evt_t e, input logic b, input int nWords, input bit withDone);
    exp_t x;
    for (int k = 0; k < nWords; k++) begin
      x.isDone = 1'b0;
      x.addr   = {1'b0, b, 6'(k)};
      x.data   = wordOf(e, k);
      expQ.push_back(x);
    end
    if (withDone) begin
      x.isDone = 1'b1;
      x.addr   = {1'b0, b, 6'd8};
      x.data   = 16'h0000;
      expQ.push_back(x);
    end
  endtask

  // Present an event and wait (bounded) until it is accepted; ends 1ns
  // after the accepting edge with the expected record already queued.
  task automatic applyStimulus(input evt_t e, input int nWords, input bit withDone, output bit ok);
    evtType   = e.typ;
    evtNumber = e.num;
    evtPps    = e.pps;
    evtClock  = e.clk;
    evtL3     = e.l3;
    evtValid  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk33);
      if (evtReady) begin
        @(posedge clk33);
        #1;
        ok = 1'b1;
        pushRecord(e, modelBuf, nWords, withDone);
      end
    end
    evtValid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout actual=0 required=1");
    end
  endtask

  // Follows cycles N+1..N+10 after an accept, optionally pulsing a clear
  // on the done cycle; ends 1ns into cycle N+11.
  task automatic waitRecord(input bit clrOnDone);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin
        @(posedge clk33);
        #1;
      end
      if (k == 10 && clrOnDone) clearEvt = 1'b1;
      @(negedge clk33);
      checkOutput("ready_low_in_record", evtReady, 1'b0);
      if (k < 10) checkOutput("write_strobe", wrStrobe, 1'b1);
      else        checkOutput("done_on_n10", doneStrobe, 1'b1);
    end
    @(posedge clk33);
    #1;
    clearEvt = 1'b0;
  endtask

  task automatic runEvent(input evt_t e, input bit clrOnDone);
    bit ok;
    applyStimulus(e, 9, 1'b1, ok);
    if (ok) begin
      waitRecord(clrOnDone);
      modelBuf = ~modelBuf;
      if (!clrOnDone) modelOcc++;
    end
  endtask

  task automatic pulseClear;
    clearEvt = 1'b1;
    @(posedge clk33);
    #1;
    clearEvt = 1'b0;
    if (modelOcc > 0) modelOcc--;
  endtask

  // Monitor: every write or done pulse must match the head of the queue.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk33);
      if (wrStrobe || doneStrobe) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_output actual=wr%0b/done%0b addr=%0h required=none", wrStrobe, doneStrobe, wrAddr);
        end else begin
          x = expQ.pop_front();
          if (x.isDone) begin
            if (!(doneStrobe && !wrStrobe && wrAddr === x.addr)) begin
              bad++;
              $display("[TB] FAIL done_pulse actual=wr%0b/done%0b addr=%0h required=done addr=%0h", wrStrobe, doneStrobe, wrAddr, x.addr);
            end
          end else begin
            if (!(wrStrobe && !doneStrobe && wrAddr === x.addr && wrDat === x.data)) begin
              bad++;
              $display("[TB] FAIL record_write actual=wr%0b addr=%0h data=%0h required=addr=%0h data=%0h", wrStrobe, wrAddr, wrDat, x.addr, x.data);
            end
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk33);
    #1;
    rst = 1'b0;

    @(negedge clk33);
    checkOutput("reset_ready", evtReady, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_occ", occupancy, 2'd0);
    checkOutput("reset_err", errUnderflow, 1'b0);
    checkOutput("reset_wr", wrStrobe, 1'b0);
    checkOutput("reset_done", doneStrobe, 1'b0);
    checkOutput("reset_addr", wrAddr, 8'h00);
    checkOutput("reset_dat", wrDat, 16'h0000);
    @(posedge clk33);
    #1;

    // Single event into buffer 0.
    runEvent(evA, 1'b0);
    @(negedge clk33);
    checkOutput("single_occ", occupancy, 32'(modelOcc));
    checkOutput("single_ready", evtReady, 1'b1);

    // Second event fills buffer 1; a third must stall until a clear.
    @(posedge clk33);
    #1;
    runEvent(evB, 1'b0);
    @(negedge clk33);
    checkOutput("full_occ", occupancy, 32'(modelOcc));
    checkOutput("full_ready", evtReady, 1'b0);
    checkOutput("full_busy", busy, 1'b1);
    evtType = evC.typ; evtNumber = evC.num; evtPps = evC.pps;
    evtClock = evC.clk; evtL3 = evC.l3;
    evtValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk33);
      checkOutput("stall_ready", evtReady, 1'b0);
    end
    @(posedge clk33);
    #1;
    pulseClear();
    runEvent(evC, 1'b0);
    @(negedge clk33);
    checkOutput("refill_occ", occupancy, 32'(modelOcc));
    @(posedge clk33);
    #1;
    pulseClear();
    pulseClear();
    @(negedge clk33);
    checkOutput("drained_occ", occupancy, 32'(modelOcc));

    // Clear coinciding with the done cycle at occupancy 1.
    @(posedge clk33);
    #1;
    runEvent(evB, 1'b0);
    runEvent(evC, 1'b1);
    @(negedge clk33);
    checkOutput("simul_occ", occupancy, 2'd1);
    checkOutput("simul_ready", evtReady, 1'b1);

    // Underflow: release at occupancy 0 is ignored but sticky-flagged.
    @(posedge clk33);
    #1;
    pulseClear();
    @(negedge clk33);
    checkOutput("pre_underflow_occ", occupancy, 2'd0);
    checkOutput("pre_underflow_err", errUnderflow, 1'b0);
    @(posedge clk33);
    #1;
    pulseClear();
    repeat (4) @(negedge clk33);
    checkOutput("underflow_occ", occupancy, 2'd0);
    checkOutput("underflow_err", errUnderflow, 1'b1);

    // Reset asserted while word 4 is being written.
    @(posedge clk33);
    #1;
    applyStimulus(evA, 5, 1'b0, ok);
    repeat (4) @(posedge clk33);
    #1;
    rst = 1'b1;
    @(posedge clk33);
    #1;
    rst = 1'b0;
    modelBuf = 1'b0;
    modelOcc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk33);
      checkOutput("abort_no_write", wrStrobe, 1'b0);
      checkOutput("abort_no_done", doneStrobe, 1'b0);
    end
    checkOutput("abort_occ", occupancy, 2'd0);
    checkOutput("abort_err_cleared", errUnderflow, 1'b0);

    // Checksum wrap, landing in buffer 0 after the reset.
    @(posedge clk33);
    #1;
    runEvent(evF, 1'b0);
    @(negedge clk33);
    checkOutput("wrap_occ", occupancy, 32'(modelOcc));

    for (int c = 0; c < 20 && expQ.size() != 0; c++) @(negedge clk33);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
